// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the arbiters in this codebase.
//   arb_state_e : two-state grant FSM encoding (IDLE, HOLD)
//   clog2       : ceiling log2, used for derived select/counter widths
//   rr_pick     : rotating-priority search; returns first set request at or
//                 above ptr (modulo n) together with a found flag
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // rr_pick works on a fixed maximum width so one function serves every
    // arbiter size; callers zero-extend their vectors into it.
    localparam int RR_MAXN = 32;
    localparam int RR_IDXW = 5;

    typedef struct packed {
        logic               found;
        logic [RR_IDXW-1:0] idx;
    } rr_pick_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // Scan n entries starting at ptr, wrapping at n; the first set bit wins.
    function automatic rr_pick_t rr_pick(input logic [RR_MAXN-1:0] req,
                                         input logic [RR_IDXW-1:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        j = 0;
        for (int k = 0; k < RR_MAXN; k++) begin
            if (k < n && !r.found) begin
                j = (int'(ptr) + k) % n;
                if (req[j[RR_IDXW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[RR_IDXW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/switcher_arbiter_if.sv
// -----------------------------------------------------------------------------
// switcher_arbiter_if
// Bundle between the requester ports and the switcher arbiter.
//   req, done           : per-requester request level and completion pulse
//   sel, gnt, gnt_valid : current owner index, one-hot grant, owner-live flag
//   timeout             : one-cycle pulse on a forced release
// Modports:
//   master : requester side (drives req/done, observes the grant)
//   slave  : arbiter side (observes req/done, drives the grant)
// -----------------------------------------------------------------------------
interface switcher_arbiter_if #(
    parameter int NREQ = 8
) ();
    localparam int SELW = arb_pkg::clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [SELW-1:0] sel;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  gnt,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output gnt,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority encoder.
//   req       : NREQ request vector
//   ptr       : index holding highest priority this cycle
//   idx       : first set request scanning upward from ptr, modulo NREQ
//   any_valid : 1 when at least one request bit is set
// -----------------------------------------------------------------------------
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int SELW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any_valid
);
    logic [RR_MAXN-1:0] req_ext;
    logic [RR_IDXW-1:0] ptr_ext;
    rr_pick_t           pick;
    logic               unused_idx_bits;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        ptr_ext             = '0;
        ptr_ext[SELW-1:0]   = ptr;
        pick                = rr_pick(req_ext, ptr_ext, NREQ);
    end

    assign idx       = pick.idx[SELW-1:0];
    assign any_valid = pick.found;

    // The shared picker returns a wider index than this instance needs.
    assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/switcher_arbiter.sv
// -----------------------------------------------------------------------------
// switcher_arbiter
// Round-robin arbiter and sequencer for the shared switcher datapath. One
// requester owns the switcher at a time; the grant is held until the owner
// pulses done, drops its request, or has held for HOLD_MAX cycles. Every
// release is followed by one idle cycle before the next grant.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : switcher_arbiter_if.slave (req/done in, sel/gnt/gnt_valid/timeout out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module switcher_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = 8,
    parameter int HOLD_MAX = 64
) (
    input  logic               clk,
    input  logic               rst,
    switcher_arbiter_if.slave  bus
);
    localparam int SELW = clog2(NREQ);
    localparam int CNTW = clog2(HOLD_MAX);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_MAX - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NREQ - 1);

    arb_state_e      state_reg, state_next;
    logic [SELW-1:0] sel_reg, sel_next;
    logic [SELW-1:0] ptr_reg, ptr_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic            gnt_valid_reg, gnt_valid_next;
    logic            timeout_reg, timeout_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;

    logic [SELW-1:0] pick_idx;
    logic            pick_valid;
    logic            owner_done;
    logic            owner_gone;
    logic            hold_expired;

    rr_priority_pick #(
        .NREQ (NREQ),
        .SELW (SELW)
    ) u_pick (
        .req       (bus.req),
        .ptr       (ptr_reg),
        .idx       (pick_idx),
        .any_valid (pick_valid)
    );

    // Only the owner's done/req bits matter while holding.
    assign owner_done   = bus.done[sel_reg];
    assign owner_gone   = !bus.req[sel_reg];
    assign hold_expired = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        gnt_valid_next = gnt_valid_reg;
        timeout_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next     = HOLD;
                    sel_next       = pick_idx;
                    gnt_valid_next = 1'b1;
                    cnt_next       = '0;
                end
            end
            HOLD: begin
                if (owner_done || owner_gone || hold_expired) begin
                    state_next     = IDLE;
                    gnt_valid_next = 1'b0;
                    cnt_next       = '0;
                    // Next search starts just past the releasing owner.
                    ptr_next       = (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
                    // Forced release only when neither normal condition applies.
                    timeout_next   = !owner_done && !owner_gone;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot grant derived from the next select so it registers alongside it.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt_next[gi] = gnt_valid_next && (sel_next == SELW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            ptr_reg       <= '0;
            cnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            gnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            gnt_valid_reg <= gnt_valid_next;
            timeout_reg   <= timeout_next;
            gnt_reg       <= gnt_next;
        end
    end

    assign bus.sel       = sel_reg;
    assign bus.gnt       = gnt_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_switcher_arbiter.sv
// -----------------------------------------------------------------------------
// tb_switcher_arbiter
// Two arbiters (HOLD_MAX=4 and HOLD_MAX=64) driven with identical stimulus and
// compared every cycle against an owner/age reference model.
// -----------------------------------------------------------------------------
module tb_switcher_arbiter;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic [7:0] req_v;
    logic [7:0] done_v;

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model state per instance: owner (-1 idle), cycles owned,
    // next-priority index, last shown select, timeout pulse.
    int m_owner [2];
    int m_age   [2];
    int m_ptr   [2];
    int m_sel   [2];
    bit m_to    [2];
    int hold_max [2];

    bit rec_en;
    bit prev_gv_b;
    int order[$];

    switcher_arbiter_if #(.NREQ(N)) ifc_a ();
    switcher_arbiter_if #(.NREQ(N)) ifc_b ();

    assign ifc_a.req  = req_v;
    assign ifc_a.done = done_v;
    assign ifc_b.req  = req_v;
    assign ifc_b.done = done_v;

    switcher_arbiter #(.NREQ(N), .HOLD_MAX(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifc_a.slave)
    );

    switcher_arbiter #(.NREQ(N), .HOLD_MAX(64)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifc_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int i, input logic [7:0] r, input logic [7:0] d, input logic rs);
        int j;
        m_to[i] = 1'b0;
        if (rs) begin
            m_owner[i] = -1;
            m_age[i]   = 0;
            m_ptr[i]   = 0;
            m_sel[i]   = 0;
        end else if (m_owner[i] < 0) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr[i] + k) % N;
                if (m_owner[i] < 0 && r[j]) begin
                    m_owner[i] = j;
                    m_sel[i]   = j;
                    m_age[i]   = 1;
                end
            end
            if (i == 0 && m_owner[i] >= 0)
                $display("[TB] cyc=%0d grant sel=%0d req=0x%02h", cyc, m_owner[i], r);
        end else if (d[m_owner[i]] || !r[m_owner[i]]) begin
            m_ptr[i]   = (m_owner[i] + 1) % N;
            m_owner[i] = -1;
        end else if (m_age[i] == hold_max[i]) begin
            m_ptr[i]   = (m_owner[i] + 1) % N;
            m_owner[i] = -1;
            m_to[i]    = 1'b1;
        end else begin
            m_age[i]++;
        end
    endtask

    task automatic check_inst(input int i, input logic [2:0] sel, input logic [7:0] gnt,
                              input logic gv, input logic to);
        logic [7:0] exp_gnt;
        exp_gnt = (m_owner[i] >= 0) ? (8'd1 << m_owner[i]) : 8'd0;
        check($sformatf("i%0d_sel", i),       32'(sel), 32'(m_sel[i]));
        check($sformatf("i%0d_gnt", i),       32'(gnt), 32'(exp_gnt));
        check($sformatf("i%0d_gnt_valid", i), 32'(gv),  32'(m_owner[i] >= 0));
        check($sformatf("i%0d_timeout", i),   32'(to),  32'(m_to[i]));
    endtask

    // One clock: update the model with the inputs the DUTs sampled, then
    // compare the registered outputs just after the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        model_step(0, req_v, done_v, rst);
        model_step(1, req_v, done_v, rst);
        #1;
        check_inst(0, ifc_a.sel, ifc_a.gnt, ifc_a.gnt_valid, ifc_a.timeout);
        check_inst(1, ifc_b.sel, ifc_b.gnt, ifc_b.gnt_valid, ifc_b.timeout);
        if (rec_en && ifc_b.gnt_valid && !prev_gv_b)
            order.push_back(int'(ifc_b.sel));
        prev_gv_b = ifc_b.gnt_valid;
    endtask

    // Hold req for a number of cycles; pulse done[owner] on the given cycle of
    // each grant (0 = never), using model instance 0 to know the owner.
    task automatic run(input int cycles, input logic [7:0] r, input int done_age);
        for (int c = 0; c < cycles; c++) begin
            req_v  = r;
            done_v = 8'h00;
            if (done_age != 0 && m_owner[0] >= 0 && m_age[0] == done_age)
                done_v = 8'd1 << m_owner[0];
            step();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rec_en  = 1'b0;
        prev_gv_b = 1'b0;
        hold_max[0] = 4;
        hold_max[1] = 64;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_age[i]   = 0;
            m_ptr[i]   = 0;
            m_sel[i]   = 0;
            m_to[i]    = 1'b0;
        end

        // Reset held with every requester asking.
        rst    = 1'b1;
        req_v  = 8'hFF;
        done_v = 8'h00;
        for (int c = 0; c < 3; c++) step();
        rst = 1'b0;

        // Round robin with done on the third grant cycle.
        rec_en = 1'b1;
        run(40, 8'hFF, 3);
        rec_en = 1'b0;
        check("rr_count", 32'(order.size() >= 9), 32'd1);
        for (int k = 0; k < 9; k++)
            if (k < order.size())
                check("rr_order", 32'(order[k]), 32'(k % N));

        // Sparse requests with pointer wrap from 6.
        run(3, 8'h00, 0);
        run(3, 8'h20, 2);
        run(10, 8'h05, 2);

        // Forced release (both hold limits).
        run(3, 8'h00, 0);
        run(70, 8'h08, 0);

        // Done on the last allowed cycle beats the timeout; then abandonment.
        run(3, 8'h00, 0);
        run(6, 8'h04, 4);
        run(3, 8'h04, 0);
        run(3, 8'h00, 0);

        // Non-owner done while requester 2 owns.
        req_v = 8'h04; done_v = 8'h00; step();
        req_v = 8'h04; done_v = 8'h20; step();
        req_v = 8'h04; done_v = 8'h20; step();

        // Reset in the middle of a grant to requester 5.
        run(3, 8'h00, 0);
        run(3, 8'h20, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(4, 8'h30, 0);

        // Randomized traffic.
        req_v = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                req_v = 8'($urandom);
            done_v = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
